// File: rtl/fir_out_pkg.sv
// Shared widths, output range limits and sample type for the FIR output requantizer.
package fir_out_pkg;

    localparam int IN_WIDTH  = 40;
    localparam int OUT_WIDTH = 16;
    localparam int SHIFT     = 24;

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef logic signed [OUT_WIDTH-1:0] sample_t;

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO; the head entry is always visible on dout while not empty.
module fir_out_fifo import fir_out_pkg::*; #(
    parameter int WIDTH = OUT_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             push_ok;
    logic             pop_ok;

    // The extra pointer bit tells a full FIFO apart from an empty one at equal addresses.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fir_output_requantizer.sv
// Rounds/saturates the 40-bit filter accumulator to 16 bits, decimates, and buffers in a FIFO.
// Define FIR_REQ_CONVERGENT_ROUND_EN for round-half-to-even instead of round-half-up.
module fir_output_requantizer import fir_out_pkg::*; #(
    parameter int IN_WIDTH   = fir_out_pkg::IN_WIDTH,
    parameter int OUT_WIDTH  = fir_out_pkg::OUT_WIDTH,
    parameter int SHIFT      = fir_out_pkg::SHIFT,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  y,
    input  logic                        y_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    output logic [15:0]                 sat_count
);

    localparam int RW = IN_WIDTH + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [RW-1:0] HALF  = {{(RW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [RW-1:0] R_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] R_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [RW-1:0]        y_ext;
    logic signed [RW-1:0]        sum;
    logic signed [RW-1:0]        r;
    logic signed [RW-1:0]        r_rnd;
    logic                        sat_hi;
    logic                        sat_lo;
    logic signed [OUT_WIDTH-1:0] q;
`ifdef FIR_REQ_CONVERGENT_ROUND_EN
    logic                        tie;
`endif

    logic                        s1_valid;
    logic signed [OUT_WIDTH-1:0] s1_data;
    logic [PW-1:0]               phase;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;

    // One extra bit keeps the rounding add from wrapping near full scale.
    always_comb begin
        y_ext = {y[IN_WIDTH-1], y};
        sum   = y_ext + HALF;
        r     = sum >>> SHIFT;
        r_rnd = r;
`ifdef FIR_REQ_CONVERGENT_ROUND_EN
        tie = (y[SHIFT-1:0] == HALF[SHIFT-1:0]);
        if (tie && r[0]) r_rnd = r - {{(RW-1){1'b0}}, 1'b1};
`endif
        sat_hi = (r_rnd > R_MAX);
        sat_lo = (r_rnd < R_MIN);
        if (sat_hi)      q = R_MAX[OUT_WIDTH-1:0];
        else if (sat_lo) q = R_MIN[OUT_WIDTH-1:0];
        else             q = r_rnd[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            sat_count <= '0;
        end else begin
            s1_valid <= y_valid;
            if (y_valid) s1_data <= q;
            if (y_valid && (sat_hi || sat_lo) && (sat_count != 16'hFFFF))
                sat_count <= sat_count + 16'd1;
        end
    end

    // Only the phase-0 sample of each group is kept, so the first sample after reset survives.
    assign push      = s1_valid && (phase == '0);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= '0;
            overflow <= 1'b0;
        end else begin
            if (s1_valid) phase <= (phase == PW'(DECIM-1)) ? '0 : phase + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    fir_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (s1_data),
        .pop   (pop),
        .dout  (out_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Self-checking bench: a DECIM=1 and a DECIM=4 instance share stimulus and are checked against a queue model.
module tb_fir_output_requantizer;
    import fir_out_pkg::*;

    localparam logic signed [39:0] ONE = 40'sh00_0100_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [39:0] y = '0;
    logic y_valid = 1'b0;
    logic out_ready = 1'b0;

    sample_t     out_data1, out_data4;
    logic        out_valid1, out_valid4;
    logic        overflow1, overflow4;
    logic [15:0] sat_count1, sat_count4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_output_requantizer #(.DECIM(1), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .rst(rst), .y(y), .y_valid(y_valid),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .overflow(overflow1), .sat_count(sat_count1)
    );

    fir_output_requantizer #(.DECIM(4), .FIFO_DEPTH(8)) dut4 (
        .clk(clk), .rst(rst), .y(y), .y_valid(y_valid),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .overflow(overflow4), .sat_count(sat_count4)
    );

    // Reference: value = floor(y / 2^24) plus a rounding decision on the remainder, then clamp.
    function automatic sample_t requant(input logic signed [39:0] v, output bit sat);
        longint val, q, rem, half;
        val  = longint'(v);
        half = longint'(1) <<< 23;
        q    = val >>> 24;
        rem  = val - (q <<< 24);
        if (rem > half) q = q + 1;
        else if (rem == half) begin
`ifdef FIR_REQ_CONVERGENT_ROUND_EN
            if (q % 2 != 0) q = q + 1;
`else
            q = q + 1;
`endif
        end
        sat = 1'b0;
        if (q > 32767)       begin q = 32767;  sat = 1'b1; end
        else if (q < -32768) begin q = -32768; sat = 1'b1; end
        return sample_t'(q);
    endfunction

    int      decim [2] = '{1, 4};
    sample_t mfifo [2][8];
    int      mcnt  [2] = '{0, 0};
    int      mphase[2] = '{0, 0};
    bit      mpend [2] = '{0, 0};
    sample_t mpdat [2];
    bit      movf  [2] = '{0, 0};
    int      msat  [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        bit pop, full, sat;
        sample_t r;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mcnt[i] = 0; mphase[i] = 0; mpend[i] = 0; movf[i] = 0; msat[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                pop  = (mcnt[i] > 0) && out_ready;
                full = (mcnt[i] == 8);
                if (pop) begin
                    for (int j = 0; j < 7; j++) mfifo[i][j] = mfifo[i][j+1];
                    mcnt[i] = mcnt[i] - 1;
                end
                if (mpend[i]) begin
                    if (full && !pop) movf[i] = 1'b1;
                    else begin
                        mfifo[i][mcnt[i]] = mpdat[i];
                        mcnt[i] = mcnt[i] + 1;
                    end
                end
                mpend[i] = 1'b0;
                if (y_valid) begin
                    r = requant(y, sat);
                    if (sat && msat[i] < 65535) msat[i] = msat[i] + 1;
                    if (mphase[i] == 0) begin
                        mpend[i] = 1'b1;
                        mpdat[i] = r;
                    end
                    mphase[i] = (mphase[i] + 1) % decim[i];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("dut1 out_valid", longint'(out_valid1), longint'(mcnt[0] > 0));
            checkOutput("dut4 out_valid", longint'(out_valid4), longint'(mcnt[1] > 0));
            if (mcnt[0] > 0) checkOutput("dut1 out_data", longint'(out_data1), longint'(mfifo[0][0]));
            if (mcnt[1] > 0) checkOutput("dut4 out_data", longint'(out_data4), longint'(mfifo[1][0]));
            checkOutput("dut1 overflow", longint'(overflow1), longint'(movf[0]));
            checkOutput("dut4 overflow", longint'(overflow4), longint'(movf[1]));
            checkOutput("dut1 sat_count", longint'(sat_count1), longint'(msat[0]));
            checkOutput("dut4 sat_count", longint'(sat_count4), longint'(msat[1]));
        end
    end

    task automatic applyStimulus(input logic signed [39:0] val, input bit vld, input bit rdy);
        @(negedge clk);
        #1;
        y         = val;
        y_valid   = vld;
        out_ready = rdy;
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst = 1'b1; y_valid = 1'b0; out_ready = 1'b0; y = '0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic signed [39:0] mult(input int k);
        return 40'(longint'(k) * longint'(ONE));
    endfunction

    int got[$];
    int firstValid;

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", longint'(out_valid1), 0);
        checkOutput("reset out_data", longint'(out_data1), 0);
        checkOutput("reset overflow", longint'(overflow1), 0);
        checkOutput("reset sat_count", longint'(sat_count4), 0);
        #1 rst = 1'b0;

        // Rounding
        applyStimulus(40'sh180_0000, 1, 0);
        applyStimulus(40'sh280_0000, 1, 0);
        applyStimulus(-40'sh180_0000, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("round 1.5", longint'(out_data1), 2);
        checkOutput("dut4 keeps first", longint'(out_data4), 2);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
`ifdef FIR_REQ_CONVERGENT_ROUND_EN
        checkOutput("round 2.5", longint'(out_data1), 2);
`else
        checkOutput("round 2.5", longint'(out_data1), 3);
`endif
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
`ifdef FIR_REQ_CONVERGENT_ROUND_EN
        checkOutput("round -1.5", longint'(out_data1), -2);
`else
        checkOutput("round -1.5", longint'(out_data1), -1);
`endif

        // Saturation: -2^39 lands exactly on the minimum, so only the two positive extremes clamp
        doReset();
        applyStimulus(40'sh7F_FFFF_FFFF, 1, 0);
        applyStimulus(40'sh80_0000_0000, 1, 0);
        applyStimulus(40'sh7F_FF80_0000, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("sat_count", longint'(sat_count1), 2);
        checkOutput("sat max", longint'(out_data1), 32767);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        checkOutput("sat min", longint'(out_data1), -32768);

        // Decimation
        doReset();
        firstValid = -1;
        got.delete();
        for (int c = 0; c < 18; c++) begin
            applyStimulus((c < 12) ? mult(c) : 40'sd0, c < 12, 1);
            if (out_valid4) begin
                if (firstValid < 0) firstValid = c;
                got.push_back(int'(out_data4));
            end
        end
        checkOutput("decim latency", firstValid, 2);
        checkOutput("decim count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) checkOutput("decim value", got[i], 4 * i);

        // Backpressure with overflow
        doReset();
        for (int k = 1; k <= 10; k++) applyStimulus(mult(k), 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("overflow set", longint'(overflow1), 1);
        got.delete();
        for (int c = 0; c < 12; c++) begin
            applyStimulus(0, 0, 1);
            if (out_valid1) got.push_back(int'(out_data1));
        end
        checkOutput("drain count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) checkOutput("drain value", got[i], i + 1);
        checkOutput("drained empty", longint'(out_valid1), 0);

        // Full FIFO with simultaneous push and pop
        doReset();
        for (int k = 1; k <= 8; k++) applyStimulus(mult(k), 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(mult(9), 1, 0);
        got.delete();
        for (int c = 0; c < 12; c++) begin
            applyStimulus(0, 0, 1);
            if (out_valid1) got.push_back(int'(out_data1));
        end
        checkOutput("push+pop overflow", longint'(overflow1), 0);
        checkOutput("push+pop count", got.size(), 9);
        for (int i = 0; i < got.size() && i < 9; i++) checkOutput("push+pop value", got[i], i + 1);

        // Reset mid-stream
        doReset();
        applyStimulus(40'sh7F_FFFF_FFFF, 1, 0);
        for (int k = 1; k <= 9; k++) applyStimulus(mult(k), 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid reset out_valid", longint'(out_valid1), 0);
        checkOutput("mid reset overflow", longint'(overflow1), 0);
        checkOutput("mid reset sat_count", longint'(sat_count1), 0);
        checkOutput("mid reset dut4 valid", longint'(out_valid4), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        applyStimulus(mult(7), 1, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("post reset kept", longint'(out_valid4), 1);
        checkOutput("post reset data", longint'(out_data4), 7);

        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
